// File: rtl/parity_cycle_sequencer_if.sv
// Request/address/data bundle between the control pulse logic, A12 and the
// parity cycle sequencer. The sequencer takes the slave side.
interface parity_cycle_sequencer_if;
    logic        gojam;
    logic        creq;
    logic [11:0] caddr;
    logic        mreq;
    logic [11:0] maddr;
    logic        mwr;
    logic [16:1] g;
    logic        almclr;

    logic [11:0] tp;
    logic        grant_c;
    logic        grant_m;
    logic [11:0] s_out;
    logic        sload;
    logic        rdstb;
    logic        chkstb;
    logic        wrstb;
    logic        done;
    logic        gp;
    logic        pale;
    logic        busy;

    modport master (
        output gojam, creq, caddr, mreq, maddr, mwr, g, almclr,
        input  tp, grant_c, grant_m, s_out, sload, rdstb, chkstb, wrstb,
               done, gp, pale, busy
    );

    modport slave (
        input  gojam, creq, caddr, mreq, maddr, mwr, g, almclr,
        output tp, grant_c, grant_m, s_out, sload, rdstb, chkstb, wrstb,
               done, gp, pale, busy
    );
endinterface

// File: rtl/parity_cycle_sequencer.sv
// Arbitrates counter vs. memory cycles, loads S, runs the 12 time-pulse
// strobe train and latches the parity alarm.
module parity_cycle_sequencer #(
    parameter int PHASES = 4,
    parameter int MAXC   = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    parity_cycle_sequencer_if.slave  bus
);
    localparam int           PW      = (PHASES > 1) ? $clog2(PHASES) : 1;
    localparam logic [PW-1:0] PH_LAST = PW'(PHASES - 1);
    localparam logic [2:0]   MAX3    = 3'(MAXC);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state;
    logic [PW-1:0] ph;
    logic [3:0]    tpi;
    logic          cpend;
    logic          mpend;
    logic [2:0]    streak;
    logic          wr;
    logic          grant_c;
    logic          grant_m;
    logic [11:0]   s_out;
    logic          pale;

    logic run;
    logic at_ph0;
    logic last_ph;
    logic done_w;
    logic arb;
    logic pick_c;
    logic pick_m;
    logic chk_w;
    logic wrs_w;

    // Arbitration slots are IDLE and the final clock of a cycle, so back-to-back
    // cycles start without a gap. Counter loses only once its streak saturates.
    always_comb begin
        run     = (state == RUN);
        at_ph0  = (ph == '0);
        last_ph = (ph == PH_LAST);
        done_w  = run && (tpi == 4'd12) && last_ph;
        arb     = !run || done_w;
        pick_c  = arb && cpend && (!mpend || (streak != MAX3));
        pick_m  = arb && mpend && !pick_c;
        chk_w   = run && (tpi == 4'd7)  && at_ph0 && !wr;
        wrs_w   = run && (tpi == 4'd10) && at_ph0 && wr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ph      <= '0;
            tpi     <= 4'd1;
            cpend   <= 1'b0;
            mpend   <= 1'b0;
            streak  <= 3'd0;
            wr      <= 1'b0;
            grant_c <= 1'b0;
            grant_m <= 1'b0;
            s_out   <= 12'd0;
        end else if (bus.gojam) begin
            state   <= IDLE;
            ph      <= '0;
            tpi     <= 4'd1;
            cpend   <= 1'b0;
            mpend   <= 1'b0;
            streak  <= 3'd0;
            grant_c <= 1'b0;
            grant_m <= 1'b0;
        end else begin
            cpend <= (cpend && !pick_c) || bus.creq;
            mpend <= (mpend && !pick_m) || bus.mreq;
            if (pick_c) begin
                state   <= RUN;
                ph      <= '0;
                tpi     <= 4'd1;
                grant_c <= 1'b1;
                grant_m <= 1'b0;
                s_out   <= bus.caddr;
                wr      <= 1'b1;
                streak  <= (streak == MAX3) ? streak : streak + 3'd1;
            end else if (pick_m) begin
                state   <= RUN;
                ph      <= '0;
                tpi     <= 4'd1;
                grant_c <= 1'b0;
                grant_m <= 1'b1;
                s_out   <= bus.maddr;
                wr      <= bus.mwr;
                streak  <= 3'd0;
            end else if (done_w) begin
                state   <= IDLE;
                ph      <= '0;
                tpi     <= 4'd1;
                grant_c <= 1'b0;
                grant_m <= 1'b0;
                streak  <= 3'd0;
            end else if (run) begin
                if (last_ph) begin
                    ph  <= '0;
                    tpi <= tpi + 4'd1;
                end else begin
                    ph <= ph + PW'(1);
                end
            end
        end
    end

    // A detected error outranks a clear on the same clock; GOJAM leaves the alarm alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pale <= 1'b0;
        end else if (chk_w && !(^bus.g)) begin
            pale <= 1'b1;
        end else if (bus.almclr) begin
            pale <= 1'b0;
        end
    end

    assign bus.tp      = run ? (12'd1 << (tpi - 4'd1)) : 12'd0;
    assign bus.grant_c = grant_c;
    assign bus.grant_m = grant_m;
    assign bus.s_out   = s_out;
    assign bus.sload   = run && (tpi == 4'd1) && at_ph0;
    assign bus.rdstb   = run && (tpi == 4'd4) && at_ph0;
    assign bus.chkstb  = chk_w;
    assign bus.wrstb   = wrs_w;
    assign bus.done    = done_w;
    assign bus.gp      = ~^bus.g[15:1];
    assign bus.pale    = pale;
    assign bus.busy    = run;
endmodule

// File: tb/tb_parity_cycle_sequencer.sv
// Directed bench for parity_cycle_sequencer: a table of single-cycle
// transactions plus hand-written multi-cycle corner sequences.
module tb_parity_cycle_sequencer;
    localparam int PHASES = 4;
    localparam int MAXC   = 3;
    localparam int NV     = 6;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    parity_cycle_sequencer_if bus ();

    parity_cycle_sequencer #(.PHASES(PHASES), .MAXC(MAXC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic        use_c;
        logic        mwr;
        logic [11:0] addr;
        logic [16:1] g;
        logic        exp_gp;
        int          exp_chk;
        int          exp_wr;
        logic        exp_pale;
    } vec_t;

    vec_t vecs [NV];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Pulse a request, then advance through the latch edge and the grant edge
    // so the caller lands in clock 1 of the new cycle.
    task automatic apply_stimulus(input logic use_c, input logic wr, input logic [11:0] addr);
        if (use_c) begin
            bus.creq  = 1'b1;
            bus.caddr = addr;
        end else begin
            bus.mreq  = 1'b1;
            bus.maddr = addr;
            bus.mwr   = wr;
        end
        tick();
        bus.creq = 1'b0;
        bus.mreq = 1'b0;
        tick();
    endtask

    initial begin
        int   sl_at, rd_at, chk_at, wr_at, done_at, n_done;
        logic busy_ok, chk_seen;
        logic grant_seen [5];
        string order;

        bus.gojam  = 1'b0;
        bus.creq   = 1'b0;
        bus.caddr  = 12'd0;
        bus.mreq   = 1'b0;
        bus.maddr  = 12'd0;
        bus.mwr    = 1'b0;
        bus.g      = 16'h0001;
        bus.almclr = 1'b0;

        vecs[0] = '{1'b0, 1'b0, 12'o1234, 16'h0002, 1'b0, 25, 0,  1'b0};
        vecs[1] = '{1'b0, 1'b0, 12'o0777, 16'h0000, 1'b1, 25, 0,  1'b1};
        vecs[2] = '{1'b0, 1'b1, 12'o7777, 16'h0000, 1'b1, 0,  37, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 12'o0042, 16'h8001, 1'b0, 0,  37, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 12'o4321, 16'hFFFF, 1'b0, 25, 0,  1'b1};
        vecs[5] = '{1'b0, 1'b0, 12'o0001, 16'h8000, 1'b1, 25, 0,  1'b0};

        #2;
        check_output("reset_tp",      32'(bus.tp),      32'd0);
        check_output("reset_grant_c", 32'(bus.grant_c), 32'd0);
        check_output("reset_grant_m", 32'(bus.grant_m), 32'd0);
        check_output("reset_s_out",   32'(bus.s_out),   32'd0);
        check_output("reset_pale",    32'(bus.pale),    32'd0);
        check_output("reset_busy",    32'(bus.busy),    32'd0);
        check_output("reset_sload",   32'(bus.sload),   32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < NV; i++) begin
            bus.g      = vecs[i].g;
            bus.almclr = 1'b1;
            tick();
            bus.almclr = 1'b0;
            check_output($sformatf("v%0d_pale_cleared", i), 32'(bus.pale), 32'd0);
            check_output($sformatf("v%0d_gp", i), 32'(bus.gp), 32'(vecs[i].exp_gp));
            apply_stimulus(vecs[i].use_c, vecs[i].mwr, vecs[i].addr);
            check_output($sformatf("v%0d_s_out", i),   32'(bus.s_out),   32'(vecs[i].addr));
            check_output($sformatf("v%0d_grant_c", i), 32'(bus.grant_c), 32'(vecs[i].use_c));
            check_output($sformatf("v%0d_grant_m", i), 32'(bus.grant_m), 32'(!vecs[i].use_c));
            sl_at = 0; rd_at = 0; chk_at = 0; wr_at = 0; done_at = 0; n_done = 0;
            for (int k = 1; k <= 48; k++) begin
                if (bus.sload  && sl_at  == 0) sl_at  = k;
                if (bus.rdstb  && rd_at  == 0) rd_at  = k;
                if (bus.chkstb && chk_at == 0) chk_at = k;
                if (bus.wrstb  && wr_at  == 0) wr_at  = k;
                if (bus.done) begin
                    n_done++;
                    if (done_at == 0) done_at = k;
                end
                if (k == 20) check_output($sformatf("v%0d_tp_T05", i), 32'(bus.tp), 32'h010);
                tick();
            end
            check_output($sformatf("v%0d_sload_clk", i), 32'(sl_at),   32'd1);
            check_output($sformatf("v%0d_rdstb_clk", i), 32'(rd_at),   32'd13);
            check_output($sformatf("v%0d_chk_clk", i),   32'(chk_at),  32'(vecs[i].exp_chk));
            check_output($sformatf("v%0d_wr_clk", i),    32'(wr_at),   32'(vecs[i].exp_wr));
            check_output($sformatf("v%0d_done_clk", i),  32'(done_at), 32'd48);
            check_output($sformatf("v%0d_done_cnt", i),  32'(n_done),  32'd1);
            check_output($sformatf("v%0d_busy_49", i),   32'(bus.busy), 32'd0);
            check_output($sformatf("v%0d_tp_49", i),     32'(bus.tp),   32'd0);
            check_output($sformatf("v%0d_pale", i),      32'(bus.pale), 32'(vecs[i].exp_pale));
        end

        // Alarm set and clear arriving on the same clock: set must win.
        bus.g      = 16'h0000;
        bus.almclr = 1'b1;
        apply_stimulus(1'b0, 1'b0, 12'o0123);
        for (int k = 1; k <= 48; k++) begin
            if (k == 26) check_output("almclr_vs_err_pale26", 32'(bus.pale), 32'd1);
            if (k == 27) check_output("almclr_clears_pale27", 32'(bus.pale), 32'd0);
            tick();
        end
        bus.almclr = 1'b0;

        // Simultaneous requests: counter first, memory follows with no gap.
        bus.g     = 16'h0001;
        bus.creq  = 1'b1;
        bus.caddr = 12'o0100;
        bus.mreq  = 1'b1;
        bus.maddr = 12'o0200;
        bus.mwr   = 1'b0;
        tick();
        bus.creq = 1'b0;
        bus.mreq = 1'b0;
        tick();
        check_output("both_first_grant_c", 32'(bus.grant_c), 32'd1);
        busy_ok = 1'b1; chk_seen = 1'b0; wr_at = 0;
        for (int k = 1; k <= 48; k++) begin
            if (!bus.busy) busy_ok = 1'b0;
            if (bus.chkstb) chk_seen = 1'b1;
            if (bus.wrstb && wr_at == 0) wr_at = k;
            tick();
        end
        check_output("both_c_wrstb_clk",  32'(wr_at),       32'd37);
        check_output("both_c_no_chkstb",  32'(chk_seen),    32'd0);
        check_output("both_m_grant_49",   32'(bus.grant_m), 32'd1);
        check_output("both_m_sload_49",   32'(bus.sload),   32'd1);
        check_output("both_m_s_out_49",   32'(bus.s_out),   32'(12'o0200));
        check_output("both_busy_contig",  32'(busy_ok && bus.busy), 32'd1);
        for (int k = 1; k <= 48; k++) tick();
        check_output("both_idle_after_m", 32'(bus.busy), 32'd0);

        // Counter streak limit: memory waits behind MAXC counter cycles.
        order = "";
        bus.creq  = 1'b1;
        bus.caddr = 12'o0010;
        bus.mreq  = 1'b1;
        bus.maddr = 12'o0020;
        tick();
        bus.creq = 1'b0;
        bus.mreq = 1'b0;
        tick();
        for (int cyc = 0; cyc < 5; cyc++) begin
            grant_seen[cyc] = bus.grant_c;
            order = {order, bus.grant_c ? "C" : (bus.grant_m ? "M" : "-")};
            for (int k = 1; k <= 48; k++) begin
                if (k == 2 && cyc < 4) bus.creq = 1'b1;
                if (k == 3) bus.creq = 1'b0;
                tick();
            end
        end
        check_output("streak_c0", 32'(grant_seen[0]), 32'd1);
        check_output("streak_c1", 32'(grant_seen[1]), 32'd1);
        check_output("streak_c2", 32'(grant_seen[2]), 32'd1);
        check_output("streak_m3", 32'(grant_seen[3]), 32'd0);
        check_output("streak_c4", 32'(grant_seen[4]), 32'd1);
        if (order != "CCCMC") $display("[TB] grant order seen: %s", order);
        check_output("streak_idle_end", 32'(bus.busy), 32'd0);

        // GOJAM at T07 ph2 with a counter request pending.
        apply_stimulus(1'b0, 1'b0, 12'o5555);
        n_done = 0;
        for (int k = 1; k < 27; k++) begin
            if (k == 2) bus.creq = 1'b1;
            if (k == 3) bus.creq = 1'b0;
            if (bus.done) n_done++;
            tick();
        end
        check_output("gojam_tp_T07", 32'(bus.tp), 32'h040);
        bus.gojam = 1'b1;
        tick();
        bus.gojam = 1'b0;
        check_output("gojam_tp",      32'(bus.tp),      32'd0);
        check_output("gojam_busy",    32'(bus.busy),    32'd0);
        check_output("gojam_grant_m", 32'(bus.grant_m), 32'd0);
        check_output("gojam_s_out",   32'(bus.s_out),   32'(12'o5555));
        for (int k = 0; k < 4; k++) begin
            if (bus.done) n_done++;
            tick();
        end
        check_output("gojam_no_done",     32'(n_done),   32'd0);
        check_output("gojam_pend_dropped", 32'(bus.busy), 32'd0);

        // Async reset in T05 after the alarm has been set.
        bus.g = 16'h0000;
        apply_stimulus(1'b0, 1'b0, 12'o1111);
        for (int k = 1; k <= 48; k++) tick();
        check_output("rst_pre_pale", 32'(bus.pale), 32'd1);
        bus.g = 16'h0001;
        apply_stimulus(1'b0, 1'b0, 12'o2222);
        for (int k = 1; k < 17; k++) tick();
        check_output("rst_pre_tp_T05", 32'(bus.tp), 32'h010);
        rst_n = 1'b0;
        #1;
        check_output("rst_async_tp",      32'(bus.tp),      32'd0);
        check_output("rst_async_busy",    32'(bus.busy),    32'd0);
        check_output("rst_async_grant_m", 32'(bus.grant_m), 32'd0);
        check_output("rst_async_s_out",   32'(bus.s_out),   32'd0);
        check_output("rst_async_pale",    32'(bus.pale),    32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        apply_stimulus(1'b0, 1'b1, 12'o3333);
        check_output("rst_after_grant_m", 32'(bus.grant_m), 32'd1);
        check_output("rst_after_s_out",   32'(bus.s_out),   32'(12'o3333));
        check_output("rst_after_sload",   32'(bus.sload),   32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
